dp_instr_encoder: RTL and testbench

- Inverse of the datapath's ALU/instruction decode path: turns a data-processing operation descriptor into a 32-bit ARM data-processing instruction word.
- Assigns each word a sequential instruction-memory address.
- Feeds the program-load/self-test path that writes instruction memory.
- Valid/ready on both sides, one request in flight, optional multi-cycle immediate rotation search.

---
 rtl/dp_instr_encoder.sv | 186 ++++++++++++++++++
 tb/tb_dp_instr_encoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dp_instr_encoder.sv
// Encodes a data-processing op descriptor into a 32-bit ARM DP word at a sequential address (optional DP_ENC_IMM_ROT_EN adds a rotated-immediate search).
// Latency 1 cycle (up to 16 more with immediate search). The word is held until out_ready, and no new request is taken in the meantime.
module dp_instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cmd,
    input  logic [3:0]        cond,
    input  logic              s,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [3:0]        rm,
    input  logic              imm_sel,
    input  logic [31:0]       imm32,
    input  logic [1:0]        sh,
    input  logic [4:0]        shamt,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    typedef enum logic [1:0] {IDLE, SEARCH, HOLD} state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_instr;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic              w_accept;
    logic              w_out_hs;
    logic              w_direct;
    logic [11:0]       w_src2_in;
    logic              w_search_done;

    // Returns {err, instr}; compare/test ops always set flags and have no destination.
    function automatic logic [32:0] encode(
        input logic [3:0]  f_cond,
        input logic [3:0]  f_cmd,
        input logic        f_s,
        input logic [3:0]  f_rn,
        input logic [3:0]  f_rd,
        input logic        f_imm,
        input logic [11:0] f_src2
    );
        logic       v_s;
        logic [3:0] v_rn;
        logic [3:0] v_rd;
        logic       v_err;
        v_s   = f_s;
        v_rn  = f_rn;
        v_rd  = f_rd;
        v_err = 1'b0;
        case (f_cmd)
            4'b0111, 4'b1110, 4'b1111: v_err = 1'b1;
            4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                v_s  = 1'b1;
                v_rd = 4'd0;
            end
            4'b1101: v_rn = 4'd0;
            default: ;
        endcase
        if (v_err)
            encode = {1'b1, 32'h0};
        else
            encode = {1'b0, f_cond, 2'b00, f_imm, f_cmd, v_s, v_rn, v_rd, f_src2};
    endfunction

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_out_hs = out_ready && (r_state == HOLD);

`ifdef DP_ENC_IMM_ROT_EN
    logic [3:0]  r_cond;
    logic [3:0]  r_cmd;
    logic        r_s;
    logic [3:0]  r_rn;
    logic [3:0]  r_rd;
    logic [31:0] r_imm32;
    logic [3:0]  r_rot;
    logic [4:0]  w_amt;
    logic [31:0] w_rol;
    logic        w_hit;

    assign w_direct      = !imm_sel;
    assign w_src2_in     = {shamt, sh, 1'b0, rm};
    assign w_amt         = {r_rot, 1'b0};
    assign w_rol         = (r_imm32 << w_amt) | (r_imm32 >> (6'd32 - {1'b0, w_amt}));
    assign w_hit         = (w_rol[31:8] == 24'd0);
    assign w_search_done = w_hit || (r_rot == 4'hF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cond  <= 4'd0;
            r_cmd   <= 4'd0;
            r_s     <= 1'b0;
            r_rn    <= 4'd0;
            r_rd    <= 4'd0;
            r_imm32 <= 32'd0;
            r_rot   <= 4'd0;
        end else if (w_accept) begin
            r_cond  <= cond;
            r_cmd   <= cmd;
            r_s     <= s;
            r_rn    <= rn;
            r_rd    <= rd;
            r_imm32 <= imm32;
            r_rot   <= 4'd0;
        end else if (r_state == SEARCH && !w_search_done) begin
            r_rot   <= r_rot + 4'd1;
        end
    end
`else
    logic w_unused_imm_hi;

    assign w_unused_imm_hi = ^imm32[31:12];
    assign w_direct        = 1'b1;
    assign w_src2_in       = imm_sel ? imm32[11:0] : {shamt, sh, 1'b0, rm};
    assign w_search_done   = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_next = w_direct ? HOLD : SEARCH;
            end
            SEARCH: begin
                if (w_search_done)
                    w_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_accept && w_direct) begin
            {r_err, r_instr} <= encode(cond, cmd, s, rn, rd, imm_sel, w_src2_in);
`ifdef DP_ENC_IMM_ROT_EN
        end else if (r_state == SEARCH && w_hit) begin
            {r_err, r_instr} <= encode(r_cond, r_cmd, r_s, r_rn, r_rd, 1'b1, {r_rot, w_rol[7:0]});
        end else if (r_state == SEARCH && r_rot == 4'hF) begin
            r_err   <= 1'b1;
            r_instr <= 32'd0;
`endif
        end
    end

    // Clear wins over the handshake increment so a clear+pop lands on BASE_ADDR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_addr <= BASE_ADDR;
        else if (addr_clr)
            r_addr <= BASE_ADDR;
        else if (w_out_hs)
            r_addr <= r_addr + ADDR_W'(4);
    end

    assign out_instr = r_instr;
    assign out_err   = r_err;
    assign out_addr  = r_addr;

endmodule

// File: tb/tb_dp_instr_encoder.sv
// Directed bench for dp_instr_encoder: hand-computed encodings, latency, addressing, backpressure and reset.
module tb_dp_instr_encoder;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [3:0]  cmd, cond, rn, rd, rm;
    logic        s, imm_sel;
    logic [31:0] imm32;
    logic [1:0]  sh;
    logic [4:0]  shamt;
    logic        addr_clr;
    logic        out_valid, out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dp_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cmd(cmd), .cond(cond), .s(s), .rn(rn), .rd(rd), .rm(rm),
        .imm_sel(imm_sel), .imm32(imm32), .sh(sh), .shamt(shamt),
        .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [3:0] t_cmd, input logic [3:0] t_cond, input logic t_s,
                         input logic [3:0] t_rn, input logic [3:0] t_rd, input logic [3:0] t_rm,
                         input logic t_imm, input logic [31:0] t_imm32,
                         input logic [1:0] t_sh, input logic [4:0] t_shamt);
        cmd = t_cmd; cond = t_cond; s = t_s; rn = t_rn; rd = t_rd; rm = t_rm;
        imm_sel = t_imm; imm32 = t_imm32; sh = t_sh; shamt = t_shamt;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int exp_lat, input logic [31:0] e_instr,
                              input logic e_err, input logic [31:0] e_addr);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_instr"}, out_instr, e_instr);
        chk({tag, "_err"}, {31'd0, out_err}, {31'd0, e_err});
        chk({tag, "_addr"}, out_addr, e_addr);
    endtask

    task automatic pop(input logic clr);
        out_ready = 1'b1;
        addr_clr  = clr;
        @(negedge clk);
        out_ready = 1'b0;
        addr_clr  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; addr_clr = 1'b0;
        cmd = 4'd0; cond = 4'd0; s = 1'b0; rn = 4'd0; rd = 4'd0; rm = 4'd0;
        imm_sel = 1'b0; imm32 = 32'd0; sh = 2'd0; shamt = 5'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_out_addr", out_addr, BASE);

        // ADD r1, r2, r3
        drive(4'b0100, 4'hE, 1'b0, 4'd2, 4'd1, 4'd3, 1'b0, 32'd0, 2'd0, 5'd0);
        expect_out("add", 1, 32'hE082_1003, 1'b0, BASE);
        pop(1'b0);
        chk("idle_after_pop", {31'd0, out_valid}, 32'd0);

        // CMP forces S=1, Rd=0
        drive(4'b1010, 4'hE, 1'b0, 4'd4, 4'd5, 4'd6, 1'b0, 32'd0, 2'd0, 5'd0);
        expect_out("cmp", 1, 32'hE154_0006, 1'b0, BASE + 32'd4);
        pop(1'b0);

        drive(4'b1110, 4'hE, 1'b1, 4'd1, 4'd1, 4'd1, 1'b0, 32'd0, 2'd0, 5'd0);
        expect_out("ill_1110", 1, 32'd0, 1'b1, BASE + 32'd8);
        pop(1'b0);
        drive(4'b0111, 4'h0, 1'b0, 4'd3, 4'd3, 4'd3, 1'b0, 32'd0, 2'd1, 5'd1);
        expect_out("ill_0111", 1, 32'd0, 1'b1, BASE + 32'd12);
        pop(1'b0);

        // MOV with cond=1111, shifted register, Rn forced to 0
        drive(4'b1101, 4'hF, 1'b1, 4'd9, 4'd2, 4'd5, 1'b0, 32'd0, 2'd2, 5'd3);
        expect_out("mov_nv", 1, 32'hF1B0_21C5, 1'b0, BASE + 32'd16);

        cmd = 4'b0100; cond = 4'hE; rn = 4'd7; rd = 4'd7; rm = 4'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_instr", out_instr, 32'hF1B0_21C5);
            chk("bp_addr", out_addr, BASE + 32'd16);
        end
        in_valid = 1'b0;
        pop(1'b1);
        chk("bp_ignored_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_addr", out_addr, BASE);
        @(negedge clk);
        chk("bp_ignored_ready", {31'd0, in_ready}, 32'd1);

`ifdef DP_ENC_IMM_ROT_EN
        drive(4'b1101, 4'hE, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 32'hFF00_0000, 2'd0, 5'd0);
        expect_out("rot_hit", 6, 32'hE3A0_04FF, 1'b0, BASE);
        pop(1'b0);
        drive(4'b1101, 4'hE, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 32'h0000_0101, 2'd0, 5'd0);
        expect_out("rot_miss", 17, 32'd0, 1'b1, BASE + 32'd4);
        pop(1'b0);
        drive(4'b1101, 4'hE, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 32'h0000_0101, 2'd0, 5'd0);
        @(negedge clk);
        chk("search_in_ready", {31'd0, in_ready}, 32'd0);
        chk("search_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_search_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_search_addr", out_addr, BASE);
        chk("rst_search_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        drive(4'b0100, 4'hE, 1'b0, 4'd2, 4'd1, 4'd3, 1'b0, 32'd0, 2'd0, 5'd0);
        expect_out("post_rst_search", 1, 32'hE082_1003, 1'b0, BASE);
        pop(1'b0);
        drive(4'b0100, 4'hE, 1'b0, 4'd2, 4'd1, 4'd3, 1'b0, 32'd0, 2'd0, 5'd0);
        expect_out("pre_hold_rst", 1, 32'hE082_1003, 1'b0, BASE + 32'd4);
`else
        // ORR immediate: only imm32[11:0] is used
        drive(4'b1100, 4'h0, 1'b1, 4'd7, 4'd8, 4'd0, 1'b1, 32'h1234_5ABC, 2'd0, 5'd0);
        expect_out("orr_imm", 1, 32'h0397_8ABC, 1'b0, BASE);
        pop(1'b0);
        drive(4'b0100, 4'hE, 1'b0, 4'd1, 4'd1, 4'd0, 1'b1, 32'hFFFF_F0FF, 2'd0, 5'd0);
        expect_out("add_imm", 1, 32'hE281_10FF, 1'b0, BASE + 32'd4);
        pop(1'b0);
        drive(4'b0100, 4'hE, 1'b0, 4'd2, 4'd1, 4'd3, 1'b0, 32'd0, 2'd0, 5'd0);
        expect_out("pre_hold_rst", 1, 32'hE082_1003, 1'b0, BASE + 32'd8);
`endif

        reset = 1'b1;
        #1;
        chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_hold_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_hold_instr", out_instr, 32'd0);
        chk("rst_hold_addr", out_addr, BASE);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        drive(4'b0100, 4'hE, 1'b0, 4'd2, 4'd1, 4'd3, 1'b0, 32'd0, 2'd0, 5'd0);
        expect_out("post_rst_hold", 1, 32'hE082_1003, 1'b0, BASE);
        pop(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
